// File: rtl/uart_rx_if.sv
// uart_rx_if: output handshake bundle of the UART receiver.
//   rx_data     : received byte, held while rx_valid is high
//   rx_valid    : rx_data and the error flags are valid
//   rx_ready    : consumer accepts; a transfer happens when rx_valid && rx_ready
//   parity_err  : received parity bit differs from ^rx_data (qualified by rx_valid)
//   frame_err   : stop bit sampled low (qualified by rx_valid)
//   overrun_err : one-cycle pulse when a completed frame is dropped
// The receiver uses the master modport and the consumer uses the slave modport.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: serial receiver for 11-bit frames (start, DATA_WIDTH data bits LSB
// first, even parity, stop). One bit period is prescale*8 clock cycles, with
// prescale latched at start detection. Each received byte is presented, along
// with its error flags, on a valid/ready output register.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   rxd      : serial line, idle high, asynchronous to clk
//   prescale : bit period divider (period = prescale*8 cycles); 0 disables
//   busy     : high from start detection until the FSM returns to IDLE
//   rx       : output handshake bundle (uart_rx_if.master)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a low line with a nonzero prescale
// START     | timing to mid start bit; a high sample means a false start
// DATA      | sampling DATA_WIDTH data bits at mid-bit, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit and delivering the frame
// WAIT_IDLE | stop bit was low (break); hold until the line returns high
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] prescale,
  output logic        busy,
  uart_rx_if.master   rx
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                state, state_n;
  logic                  sync_1, rxd_s;
  logic [1:0]            hist;
  logic                  maj;
  logic [18:0]           timer, timer_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [15:0]           p_q, p_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_q, par_n;
  logic                  stop_hit;
  logic [18:0]           load_half;
  logic [18:0]           load_bit;
  logic                  timer_zero;

  // Two-flop synchronizer plus two prior samples for the majority vote.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b1;
      rxd_s  <= 1'b1;
      hist   <= 2'b11;
    end else begin
      sync_1 <= rxd;
      rxd_s  <= sync_1;
      hist   <= {hist[0], rxd_s};
    end
  end

  assign maj = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);

  // Reload values are formed at the full 19-bit timer width. The half-bit
  // value uses the live prescale because it is loaded in the same cycle that
  // prescale is latched.
  assign load_half  = {1'b0, prescale, 2'b00} - 19'd1;
  assign load_bit   = {p_q, 3'b000} - 19'd1;
  assign timer_zero = (timer == 19'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer_zero ? timer : timer - 19'd1;
    bit_cnt_n = bit_cnt;
    p_n       = p_q;
    shreg_n   = shreg;
    par_n     = par_q;
    stop_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s && (prescale != 16'd0)) begin
          state_n = START;
          p_n     = prescale;
          timer_n = load_half;
        end
      end
      START: begin
        if (timer_zero) begin
          if (maj) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            timer_n   = load_bit;
            bit_cnt_n = '0;
          end
        end
      end
      DATA: begin
        if (timer_zero) begin
          shreg_n = {maj, shreg[DATA_WIDTH-1:1]};
          timer_n = load_bit;
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            state_n = PARITY;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      PARITY: begin
        if (timer_zero) begin
          par_n   = maj;
          timer_n = load_bit;
          state_n = STOP;
        end
      end
      STOP: begin
        if (timer_zero) begin
          stop_hit = 1'b1;
          state_n  = maj ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxd_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      p_q     <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      p_q     <= p_n;
      shreg   <= shreg_n;
      par_q   <= par_n;
    end
  end

  // Output register. A frame completing while the previous one is still held
  // (and not being taken this cycle) is dropped and flagged as an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx.rx_data     <= '0;
      rx.rx_valid    <= 1'b0;
      rx.parity_err  <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.overrun_err <= 1'b0;
    end else begin
      rx.overrun_err <= 1'b0;
      if (stop_hit) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data    <= shreg;
          rx.parity_err <= par_q ^ (^shreg);
          rx.frame_err  <= ~maj;
          rx.rx_valid   <= 1'b1;
        end else begin
          rx.overrun_err <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd4;
  logic        busy;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .prescale (prescale),
    .busy     (busy),
    .rx       (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   ovr_cnt = 0;

  function automatic void check(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Transmitter model: drives one frame bit by bit, 8*p cycles per bit. The
  // expected receiver output is derived from the frame contents alone.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int p, input int glitch_bit, input bit scramble,
                            input bit expect_it);
    logic b [0:10];
    exp_t e;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9]  = par;
    b[10] = stp;
    prescale = 16'(p);
    if (expect_it) begin
      e.d  = d;
      e.pe = par ^ (^d);
      e.fe = ~stp;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      rxd = b[i];
      if (i == glitch_bit) begin
        tick(4 * p);
        rxd = ~b[i];
        tick(1);
        rxd = b[i];
        tick(4 * p - 1);
      end else begin
        tick(8 * p);
      end
      if (i == 0 && scramble) prescale = 16'($urandom_range(1, 9));
    end
  endtask

  // Monitor: a frame is presented when rx_valid is high and either it was low
  // at the previous sample or a transfer completed at the intervening edge.
  initial begin
    logic pv, pr;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
        pr = 1'b0;
      end else begin
        if (bus.overrun_err) ovr_cnt++;
        if (bus.rx_valid && (!pv || pr)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'd0, bus.rx_data}, -1);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", bus.rx_data, e.d);
            check("parity_err", bus.parity_err, e.pe);
            check("frame_err", bus.frame_err, e.fe);
          end
        end
        pv = bus.rx_valid;
        pr = bus.rx_ready;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat_n;
    bit   got;
    int   busy_cnt;
    int   ovr_base;
    int   p;
    int   g;
    logic [7:0] d;
    logic par, stp;

    bus.rx_ready = 1'b1;
    rst      = 1'b0;
    rxd      = 1'b1;
    prescale = 16'd4;
    tick(3);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", bus.overrun_err, 0);
    rst = 1'b1;
    tick(5);

    // Clean frame with valid latency: rx_valid first seen after edge 84P+3
    // counted from the pin edge (2 synchronizer edges + T0 edge).
    lat_n = 0;
    got   = 1'b0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 1000 && !got; i++) begin
          @(posedge clk);
          lat_n++;
          @(negedge clk);
          if (bus.rx_valid) got = 1'b1;
        end
      end
    join
    check("valid_latency", lat_n, 84 * 4 + 3);
    tick(4);

    send_frame(8'h01, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1);
    tick(4);

    // Break: one frame of zeros with frame_err, busy held until the line rises.
    prescale = 16'd4;
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
    rxd = 1'b0;
    tick(240 * 4 - 1);
    @(negedge clk);
    check("break_busy_held", busy, 1);
    tick(1);
    rxd = 1'b1;
    tick(6);
    @(negedge clk);
    check("break_busy_released", busy, 0);
    tick(32);

    // False start of 2P cycles: busy high for exactly 4P cycles, no frame.
    prescale = 16'd4;
    busy_cnt = 0;
    fork
      begin
        rxd = 1'b0;
        tick(8);
        rxd = 1'b1;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (busy) busy_cnt++;
        end
      end
    join
    check("false_start_busy_cycles", busy_cnt, 16);
    tick(4);
    send_frame(8'hFF, 1'b0, 1'b1, 4, 4, 1'b0, 1'b1);
    tick(4);

    // prescale of zero: the line is ignored.
    prescale = 16'd0;
    rxd = 1'b0;
    tick(40);
    @(negedge clk);
    check("prescale_zero_busy", busy, 0);
    tick(1);
    rxd = 1'b1;
    tick(8);

    // Overrun: second frame dropped while the first is held.
    bus.rx_ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 4, -1, 1'b0, 1'b0);
    tick(4);
    @(negedge clk);
    check("overrun_pulses", ovr_cnt - ovr_base, 1);
    check("overrun_data_kept", bus.rx_data, 8'h11);
    check("overrun_valid_kept", bus.rx_valid, 1);
    tick(1);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    check("valid_falls_after_xfer", bus.rx_valid, 0);
    tick(2);

    // Reset mid-DATA with a frame held on the output.
    send_frame(8'h3C, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1);
    tick(2);
    prescale = 16'd4;
    rxd = 1'b0;
    tick(32);
    rxd = 1'b1;
    tick(16);
    rxd = 1'b0;
    tick(8);
    rst = 1'b0;
    #1;
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_parity_err", bus.parity_err, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_overrun", bus.overrun_err, 0);
    check("rst_busy", busy, 0);
    rxd = 1'b1;
    tick(3);
    rst = 1'b1;
    bus.rx_ready = 1'b1;
    tick(8);
    send_frame(8'h96, 1'b0, 1'b1, 4, -1, 1'b0, 1'b1);
    tick(4);

    // Random frames: random prescale, parity/stop errors, glitches and
    // mid-frame prescale changes.
    for (int k = 0; k < 40; k++) begin
      p   = int'($urandom_range(1, 6));
      d   = 8'($urandom);
      par = (^d) ^ ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      g   = int'($urandom_range(0, 19));
      send_frame(d, par, stp, p, (g >= 1 && g <= 9) ? g : -1, 1'b1, 1'b1);
      rxd = 1'b1;
      tick(stp ? int'($urandom_range(0, 6)) : 8 * p + 2);
    end

    // Back-to-back loopback stream at prescale 1.
    for (int k = 0; k < 256; k++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, 1, -1, 1'b0, 1'b1);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick(1);
    tick(4);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_total", ovr_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath: recovers 11-bit frames (start, 8 data bits LSB first, even parity, stop) from the `rxd` line using the same prescale convention as the transmitter, where one bit period equals `prescale*8` clock cycles. It sits directly downstream of the transmit line and presents each received byte, with its error flags, on a valid/ready output register for the AXI-Lite register block.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame. The frame is always start + `DATA_WIDTH` + parity + stop.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `prescale` input 16: bit period is `prescale*8` cycles; latched at start detection.
- `rx_data` output DATA_WIDTH: received byte, held while `rx_valid`=1.
- `rx_valid` output 1: `rx_data` and the flags are valid.
- `rx_ready` input 1: consumer accepts; transfer occurs when `rx_valid && rx_ready`.
- `parity_err` output 1: qualified by `rx_valid`; set when the received parity is not equal to `^rx_data`.
- `frame_err` output 1: qualified by `rx_valid`; set when the stop bit sampled 0.
- `overrun_err` output 1: one-cycle pulse when a completed frame is dropped.
- `busy` output 1: high from start detection until the FSM returns to IDLE.

## Operation
- **Input conditioning**
  - `rxd` passes through a 2-flop synchronizer, giving `rxd_s`. Both flops reset to 1.
  - A 3-entry history keeps the current `rxd_s` and the two prior values.
  - The sampled bit value is the majority of these 3 entries.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - **IDLE:** when `rxd_s`=0 and `prescale`≠0, call this cycle T0. Latch `prescale` into P, load `timer` = 4P-1, set `busy`=1, go to START. If `prescale`=0 the receiver stays in IDLE and ignores the line.
  - **START:** on `timer`==0, sample the majority. If 1, it is a false start: go to IDLE and set `busy`=0. If 0, load `timer` = 8P-1, clear `bit_cnt`, go to DATA.
  - **DATA:** on each `timer`==0, shift the majority into the shift register from the MSB side, so bit 0 is received first. Reload `timer` = 8P-1. After `DATA_WIDTH` samples, go to PARITY.
  - **PARITY:** on `timer`==0, store the parity bit, reload the timer, go to STOP.
  - **STOP:** on `timer`==0, sample the stop bit and perform delivery (below). If the stop bit is 1, go to IDLE. If it is 0, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rxd_s`=1, then go to IDLE. This prevents a line break from retriggering frames.
- **Arithmetic:** `timer` is 19 bits. 8P-1 is computed at full width and never truncated.
- **Delivery** (on the stop-sample cycle):
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: load `rx_data`, `parity_err` and `frame_err`, and assert `rx_valid` on the next cycle.
  - Otherwise the new frame is discarded, the old data and flags are kept, and `overrun_err` pulses for 1 cycle.
  - A frame with `frame_err` or `parity_err` is still delivered, with its flag set.
- **Handshake:** `rx_valid` falls the cycle after `rx_valid && rx_ready`, unless a new frame loads in that same cycle. In that case `rx_valid` stays 1 with the new data.
- **Reset (asynchronous, at any time including mid-frame):**
  - FSM goes to IDLE; `timer` and `bit_cnt` clear to 0.
  - Outputs: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `busy`=0.
  - A frame in progress is lost; no partial delivery occurs.
- A change on `prescale` mid-frame has no effect until the next start detection.

## Timing
- The synchronizer adds 2 cycles from a pin edge to `rxd_s`.
- Sample instants, relative to T0:
  - Start: T0+4P.
  - Data bit k: T0+4P+8P(k+1).
  - Parity: T0+76P.
  - Stop: T0+84P.
- `rx_valid` is first seen high at T0+84P+1.
- The return to IDLE happens at mid-stop. A start edge arriving 4P cycles later (back-to-back frames) is detected.
- The minimum low pulse rejected as a false start is anything shorter than about 4P cycles. The 3-sample majority additionally rejects single-cycle glitches at sample instants.
- The output register sustains one frame per 88P cycles with `rx_ready` held at 1 and no loss.

## Test plan
- **Clean frame:** `prescale`=4, line carries 0xA5 with parity 0 and stop 1 → `rx_data`=0xA5, `rx_valid` rises at T0+337, `parity_err`=0, `frame_err`=0.
- **Parity error:** send 0x01 with parity bit 0 → `rx_data`=0x01, `parity_err`=1, `frame_err`=0.
- **Break:** `rxd` held low for 30 bit periods, then high → exactly one frame: `rx_data`=0x00, `frame_err`=1, `parity_err`=0. `busy` stays 1 through WAIT_IDLE and drops after the line goes high.
- **Glitch rejection:** `rxd` low pulse of 2P cycles, then a single-cycle low spike at mid-bit during a 0xFF frame → the pulse produces no frame, `busy` returns to 0 at T0+4P+1, and the 0xFF frame is received correctly.
- **Overrun:** `rx_ready`=0, back-to-back 0x11 then 0x22 → `rx_data` stays 0x11, `overrun_err` pulses exactly once. Then `rx_ready`=1 for 1 cycle → `rx_valid` falls on the next cycle.
- **Loopback and reset:**
  - Loop back to `uart_tx` at `prescale`=1 and send 256 random bytes → all received in order with no errors.
  - Assert `rst` low mid-DATA → all outputs are 0 immediately, and the next full frame is received correctly.
